// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: handshake state encoding
// and the state-register width reused by other sequential primitives.
package mul_seq_pkg;

    localparam int MS_STATE_W = 2;

    typedef enum logic [MS_STATE_W-1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

endpackage : mul_seq_pkg

// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle for mul_seq. The producer/consumer side
// uses the master modport and the multiplier uses the slave modport.
interface mul_seq_if #(
    parameter int LEN = 32
);

    logic               mul_seq_in_valid;
    logic               mul_seq_in_ready;
    logic               mul_seq_signed;
    logic [LEN-1:0]     mul_seq_in_1;
    logic [LEN-1:0]     mul_seq_in_2;
    logic               mul_seq_out_valid;
    logic               mul_seq_out_ready;
    logic [2*LEN-1:0]   mul_seq_out;

    modport master (
        output mul_seq_in_valid,
        output mul_seq_signed,
        output mul_seq_in_1,
        output mul_seq_in_2,
        output mul_seq_out_ready,
        input  mul_seq_in_ready,
        input  mul_seq_out_valid,
        input  mul_seq_out
    );

    modport slave (
        input  mul_seq_in_valid,
        input  mul_seq_signed,
        input  mul_seq_in_1,
        input  mul_seq_in_2,
        input  mul_seq_out_ready,
        output mul_seq_in_ready,
        output mul_seq_out_valid,
        output mul_seq_out
    );

endinterface : mul_seq_if

// File: rtl/mul_seq_add.sv
// Unsigned LEN-bit adder with the carry returned as the top bit of a
// LEN+1-bit sum.
module mul_seq_add #(
    parameter int LEN = 32
) (
    input  logic [LEN-1:0] a_i,
    input  logic [LEN-1:0] b_i,
    output logic [LEN:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : mul_seq_add

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier: takes |in_1|*|in_2| over exactly LEN
// BUSY cycles with a single adder, then applies the sign and holds the product.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    localparam int              CW     = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [LEN-1:0]  ONE_L  = {{(LEN-1){1'b0}}, 1'b1};
    localparam logic [2*LEN-1:0] ONE_2L = {{(2*LEN-1){1'b0}}, 1'b1};

    ms_state_e          state_q, state_d;
    logic [LEN-1:0]     mcand_q, mcand_d;
    logic [LEN-1:0]     acc_q, acc_d;
    logic [LEN-1:0]     mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*LEN-1:0]   out_q, out_d;

    logic [LEN-1:0]     addend_s;
    logic [LEN:0]       sum_s;
    logic [2*LEN-1:0]   prod_s;
    logic [LEN-1:0]     mag1_s, mag2_s;
    logic               in_neg_s;

    // The most-negative input negates to itself, which read unsigned is 2^(LEN-1).
    assign mag1_s   = (bus.mul_seq_signed && bus.mul_seq_in_1[LEN-1]) ?
                      ((~bus.mul_seq_in_1) + ONE_L) : bus.mul_seq_in_1;
    assign mag2_s   = (bus.mul_seq_signed && bus.mul_seq_in_2[LEN-1]) ?
                      ((~bus.mul_seq_in_2) + ONE_L) : bus.mul_seq_in_2;
    assign in_neg_s = bus.mul_seq_signed & (bus.mul_seq_in_1[LEN-1] ^ bus.mul_seq_in_2[LEN-1]);

    assign addend_s = mplier_q[0] ? mcand_q : {LEN{1'b0}};

    mul_seq_add #(.LEN(LEN)) u_add (
        .a_i   (acc_q),
        .b_i   (addend_s),
        .sum_o (sum_s)
    );

    // Full product after the last step: {carry, acc, multiplier} shifted right once.
    assign prod_s = {sum_s, mplier_q[LEN-1:1]};

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        case (state_q)
            MS_IDLE: begin
                if (bus.mul_seq_in_valid) begin
                    mcand_d  = mag1_s;
                    mplier_d = mag2_s;
                    neg_d    = in_neg_s;
                    acc_d    = {LEN{1'b0}};
                    cnt_d    = CW'(LEN - 1);
                    state_d  = MS_BUSY;
                end else begin
                    state_d  = MS_IDLE;
                end
            end
            MS_BUSY: begin
                acc_d    = sum_s[LEN:1];
                mplier_d = {sum_s[0], mplier_q[LEN-1:1]};
                if (cnt_q == {CW{1'b0}}) begin
                    cnt_d   = {CW{1'b0}};
                    out_d   = neg_q ? ((~prod_s) + ONE_2L) : prod_s;
                    state_d = MS_DONE;
                end else begin
                    cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    state_d = MS_BUSY;
                end
            end
            MS_DONE: begin
                if (bus.mul_seq_out_ready) begin
                    state_d = MS_IDLE;
                end else begin
                    state_d = MS_DONE;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            mcand_q  <= {LEN{1'b0}};
            acc_q    <= {LEN{1'b0}};
            mplier_q <= {LEN{1'b0}};
            neg_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            out_q    <= {(2*LEN){1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign bus.mul_seq_in_ready  = (state_q == MS_IDLE);
    assign bus.mul_seq_out_valid = (state_q == MS_DONE);
    assign bus.mul_seq_out       = out_q;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Directed and randomized bench for mul_seq at LEN=8 and LEN=32, checking
// latency, handshake behaviour, reset abort and products against a model.
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_seq_if #(.LEN(8))  b8();
    mul_seq_if #(.LEN(32)) b32();

    mul_seq #(.LEN(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
    mul_seq #(.LEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    int     err_cnt = 0;
    int     chk_cnt = 0;
    longint cyc = 0;
    longint last_acc8 = -1;
    longint last_acc32 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Present a pair in IDLE and return just after the accept edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        @(negedge clk);
        check_val({tag, "_in_ready"}, {63'd0, b8.mul_seq_in_ready}, 64'd1);
        b8.mul_seq_in_1    = a;
        b8.mul_seq_in_2    = b;
        b8.mul_seq_signed  = s;
        b8.mul_seq_in_valid = 1'b1;
        @(posedge clk); #1;
        b8.mul_seq_in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid, noting whether in_ready ever rose.
    task automatic wait8(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!b8.mul_seq_out_valid && n < 100) begin
            if (b8.mul_seq_in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (b8.mul_seq_in_ready) busy_ok = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input string tag);
        int n;
        logic ok;
        b8.mul_seq_out_ready = 1'b1;
        start8(a, b, s, tag);
        wait8(n, ok);
        check_val({tag, "_lat"}, 64'(n), 64'd8);
        check_val({tag, "_busy"}, {63'd0, ok}, 64'd1);
        check_val({tag, "_out"}, {48'd0, b8.mul_seq_out}, {48'd0, exp});
        @(posedge clk); #1;
        check_val({tag, "_idle"}, {62'd0, b8.mul_seq_in_ready, b8.mul_seq_out_valid}, 64'd2);
    endtask

    // One back-to-back step with in_valid left high: accept spacing and product.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        @(negedge clk);
        b8.mul_seq_in_1     = a;
        b8.mul_seq_in_2     = b;
        b8.mul_seq_signed   = s;
        b8.mul_seq_in_valid = 1'b1;
        check_val("b2b8_ready", {63'd0, b8.mul_seq_in_ready}, 64'd1);
        @(posedge clk); #1;
        if (last_acc8 >= 0) check_val("b2b8_gap", 64'(cyc - last_acc8), 64'd10);
        last_acc8 = cyc;
        n = 0;
        while (!b8.mul_seq_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b8_timeout", {63'd0, n < 100}, 64'd1);
        check_val("b2b8_out", {48'd0, b8.mul_seq_out}, {48'd0, ref8(a, b, s)});
    endtask

    task automatic step32(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        @(negedge clk);
        b32.mul_seq_in_1     = a;
        b32.mul_seq_in_2     = b;
        b32.mul_seq_signed   = s;
        b32.mul_seq_in_valid = 1'b1;
        check_val("b2b32_ready", {63'd0, b32.mul_seq_in_ready}, 64'd1);
        @(posedge clk); #1;
        if (last_acc32 >= 0) check_val("b2b32_gap", 64'(cyc - last_acc32), 64'd34);
        last_acc32 = cyc;
        n = 0;
        while (!b32.mul_seq_out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b32_timeout", {63'd0, n < 200}, 64'd1);
        check_val("b2b32_out", b32.mul_seq_out, ref32(a, b, s));
    endtask

    initial begin
        int   n;
        logic ok;
        logic held;
        logic spur;

        b8.mul_seq_in_valid   = 1'b0;
        b8.mul_seq_signed     = 1'b0;
        b8.mul_seq_in_1       = 8'd0;
        b8.mul_seq_in_2       = 8'd0;
        b8.mul_seq_out_ready  = 1'b1;
        b32.mul_seq_in_valid  = 1'b0;
        b32.mul_seq_signed    = 1'b0;
        b32.mul_seq_in_1      = 32'd0;
        b32.mul_seq_in_2      = 32'd0;
        b32.mul_seq_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", {63'd0, b8.mul_seq_in_ready}, 64'd1);
        check_val("rst_out_valid", {63'd0, b8.mul_seq_out_valid}, 64'd0);
        check_val("rst_out", {48'd0, b8.mul_seq_out}, 64'd0);
        check_val("rst_out32", b32.mul_seq_out, 64'd0);
        rst = 1'b0;

        run8(8'd13,  8'd11, 1'b0, 16'd143,  "u13x11");
        run8(8'hF3,  8'd11, 1'b1, 16'hFF71, "s_m13x11");
        run8(8'h80,  8'h80, 1'b1, 16'h4000, "s_min_sq");
        run8(8'h80,  8'h80, 1'b0, 16'h4000, "u_80sq");
        run8(8'hFF,  8'hFF, 1'b0, 16'hFE01, "u_ffsq");
        run8(8'h00,  8'hFF, 1'b1, 16'h0000, "s_zero");

        // Backpressure: product held, new in_valid ignored for 20 cycles.
        b8.mul_seq_out_ready = 1'b0;
        start8(8'd13, 8'd11, 1'b0, "bp");
        wait8(n, ok);
        check_val("bp_lat", 64'(n), 64'd8);
        check_val("bp_out", {48'd0, b8.mul_seq_out}, 64'd143);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b8.mul_seq_in_valid = 1'b1;
            b8.mul_seq_in_1     = 8'd99;
            b8.mul_seq_in_2     = 8'd2;
            @(posedge clk); #1;
            if (b8.mul_seq_out !== 16'd143 || b8.mul_seq_out_valid !== 1'b1 ||
                b8.mul_seq_in_ready !== 1'b0) held = 1'b0;
        end
        check_val("bp_held", {63'd0, held}, 64'd1);
        b8.mul_seq_in_valid  = 1'b0;
        b8.mul_seq_out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release", {62'd0, b8.mul_seq_in_ready, b8.mul_seq_out_valid}, 64'd2);
        check_val("bp_out_kept", {48'd0, b8.mul_seq_out}, 64'd143);
        run8(8'd7, 8'd6, 1'b0, 16'd42, "u7x6");

        // Reset during the fourth BUSY cycle aborts the operation.
        start8(8'd100, 8'd3, 1'b0, "rmid");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rmid_in_ready", {63'd0, b8.mul_seq_in_ready}, 64'd1);
        check_val("rmid_out_valid", {63'd0, b8.mul_seq_out_valid}, 64'd0);
        check_val("rmid_out", {48'd0, b8.mul_seq_out}, 64'd0);
        spur = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (b8.mul_seq_out_valid !== 1'b0) spur = 1'b1;
        end
        check_val("rmid_spurious", {63'd0, spur}, 64'd0);
        run8(8'd3, 8'd5, 1'b0, 16'd15, "u3x5");

        // Back-to-back with in_valid held high.
        last_acc8 = -1;
        for (int i = 0; i < 1000; i++) begin
            step8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        b8.mul_seq_in_valid = 1'b0;

        last_acc32 = -1;
        step32(32'h8000_0000, 32'h8000_0000, 1'b1);
        step32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step32(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        step32(32'd0, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step32($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        b32.mul_seq_in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_mul_seq

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier; one operand pair per transaction, valid/ready handshake on both sides.
- Consumes operands produced by the combinational datapath primitives.
- Returns a full-width 2*LEN product to the downstream consumer.
- Used where a combinational LEN x LEN multiplier would break timing; trades LEN cycles of latency for one adder.

Parameters:
- LEN, 32, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mul_seq_in_valid  input  1  operand pair and mode are valid this cycle.
- mul_seq_in_ready  output  1  block can accept a new pair; equals (state==IDLE).
- mul_seq_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with operands.
- mul_seq_in_1  input  LEN  multiplicand.
- mul_seq_in_2  input  LEN  multiplier.
- mul_seq_out_valid  output  1  product is valid; equals (state==DONE).
- mul_seq_out_ready  input  1  consumer accepts product this cycle.
- mul_seq_out  output  2*LEN  product, held stable while out_valid is high.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; in_ready=1; out_valid=0; mul_seq_out=0; counter=0; internal registers cleared.
  - Reset overrides every other event, including mid-BUSY and DONE. An in-flight operation is discarded and produces no output.
- States: IDLE, BUSY, DONE.
- IDLE, at an edge with in_valid=1 (accept):
  - Latch magnitudes |in_1| and |in_2|. Magnitude is the raw value when signed=0.
  - Latch neg = signed & (in_1[LEN-1] ^ in_2[LEN-1]).
  - Clear accumulator; counter=LEN-1; state=BUSY.
  - With in_valid=0, remain in IDLE.
- BUSY, each edge:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator. The add is LEN+1 bits wide so the carry is kept.
  - Shift {carry, acc, multiplier} right by 1.
  - Decrement counter.
  - At the edge where counter==0: write the final product, two's-complement negated when neg=1, to mul_seq_out; state=DONE.
- Latency: accept at edge E0; out_valid rises in the cycle after edge E0+LEN. Exactly LEN BUSY cycles, independent of operand values; no early termination.
- DONE:
  - out_valid=1; mul_seq_out stable.
  - At an edge with out_ready=1: state=IDLE, out_valid=0. mul_seq_out keeps its value (not cleared).
  - out_ready low: hold indefinitely.
- No overlap: in_ready=0 in BUSY and DONE. in_valid is ignored outside IDLE and inputs may change freely then.
- Maximum throughput: one product per LEN+2 cycles (accept, LEN BUSY cycles, DONE handshake).
- Width and arithmetic:
  - Unsigned result = in_1*in_2 mod 2^(2LEN), which is exact.
  - Signed result is exact in 2*LEN bits, including (-2^(LEN-1))*(-2^(LEN-1)) = 2^(2LEN-2).
  - Magnitude of the most-negative value is 2^(LEN-1), held unsigned in LEN bits.
- Zero operands follow the normal path with no shortcut; result is 0 and neg is irrelevant (-0 = 0).
- Outputs are registered; there are no combinational paths from in_* to out_*.
- in_ready and out_valid decode directly from state flops.

Decomposition:
- Shared header synq_seq_defs.vh holds:
  - state encoding localparams MS_IDLE=2'd0, MS_BUSY=2'd1, MS_DONE=2'd2;
  - the handshake-state width constant, reused by later sequential primitives.
- Accumulator adder: one instance of the existing add component (LEN=LEN); its LEN+1-bit output supplies the carry.
- Final negation and magnitude extraction stay inline. No other sub-modules.

Test Plan (LEN=8 unless noted):
- Unsigned, in_1=8'd13, in_2=8'd11, signed=0, out_ready=1 -> out_valid rises exactly 8 cycles after the accept edge; out=16'd143; in_ready low for 9 cycles.
- Signed, in_1=8'hF3 (-13), in_2=8'd11, signed=1 -> out=16'hFF71 (-143). Then 8'h80 x 8'h80 signed -> 16'h4000; unsigned -> 16'h4000. Then 8'hFF x 8'hFF unsigned -> 16'hFE01.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out held 16'd143, in_ready=0 throughout, a new in_valid is ignored. Raise out_ready -> IDLE next cycle; new pair 7x6 then yields 42.
- Reset mid-op: assert rst on the 4th BUSY cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, out=0. No spurious out_valid afterwards. A following 3x5 yields 15.
- Zero and back-to-back: 0 x 8'hFF signed -> out=0 after 8 cycles. With in_valid held high continuously, observe one accept per 10 cycles (LEN+2) and results matching a reference model over 1000 random pairs. Repeat with LEN=32.
